if_id_pipe: RTL and testbench

Parametrised fetch-to-decode pipeline stage that replaces the fixed stall-only IF/ID register. It carries PC, PC+4, instruction and an interrupt tag from fetch to decode under a valid/ready handshake and supports a synchronous flush that squashes in-flight instructions to a NOP bubble. An optional 2-entry skid buffer registers `in_ready`, giving full throughput without a combinational ready path. It also keeps a saturating count of decode backpressure cycles for the performance monitor.

---
 rtl/if_id_pipe.sv | 131 +++++++++++++
 tb/tb_if_id_pipe.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/if_id_pipe.sv
// IF/ID pipeline stage: valid/ready handshake, flush to a NOP bubble, saturating backpressure counter.
// Define IF_ID_SKID_EN to build the 2-entry skid buffer with a registered in_ready.
module if_id_pipe #(
  parameter int unsigned       PC_W     = 32,
  parameter int unsigned       INST_W   = 32,
  parameter logic [INST_W-1:0] NOP_INST = INST_W'(32'h0000_0000),
  parameter int unsigned       CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PC_W-1:0]   in_pc,
  input  logic [INST_W-1:0] in_inst,
  input  logic              in_intr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PC_W-1:0]   out_pc,
  output logic [PC_W-1:0]   out_pc4,
  output logic [INST_W-1:0] out_inst,
  output logic              out_intr,
  output logic [CNT_W-1:0]  stall_cnt
);

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [PC_W-1:0]   pc4;
    logic [INST_W-1:0] inst;
    logic              intr;
  } entry_t;

  localparam entry_t           BUBBLE  = '{pc: '0, pc4: '0, inst: NOP_INST, intr: 1'b0};
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

`ifdef IF_ID_SKID_EN
  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;
  entry_t skid_q;
  logic   in_ready_q;
`else
  typedef enum logic [0:0] {EMPTY, ONE} state_t;
`endif

  state_t state;
  entry_t head_q;
  entry_t in_entry;
  logic   accept;
  logic   drain;

  assign in_entry = '{pc: in_pc, pc4: in_pc + PC_W'(4), inst: in_inst, intr: in_intr};

`ifdef IF_ID_SKID_EN
  assign in_ready = in_ready_q;
`else
  // Reset outranks the handshake, so advertising ready while it is asserted is harmless.
  assign in_ready = rst || !out_valid || out_ready;
`endif

  assign accept = in_valid && in_ready;
  assign drain  = out_valid && out_ready;

  assign out_pc   = head_q.pc;
  assign out_pc4  = head_q.pc4;
  assign out_inst = head_q.inst;
  assign out_intr = head_q.intr;

  // Occupancy FSM, payload registers and stall counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= EMPTY;
      head_q    <= BUBBLE;
      out_valid <= 1'b0;
      stall_cnt <= '0;
`ifdef IF_ID_SKID_EN
      skid_q     <= BUBBLE;
      in_ready_q <= 1'b1;
`endif
    end else begin
      if (out_valid && !out_ready && stall_cnt != CNT_MAX) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
      if (flush) begin
        state     <= EMPTY;
        head_q    <= BUBBLE;
        out_valid <= 1'b0;
`ifdef IF_ID_SKID_EN
        in_ready_q <= 1'b1;
`endif
      end else begin
        case (state)
          EMPTY: begin
            if (accept) begin
              state     <= ONE;
              head_q    <= in_entry;
              out_valid <= 1'b1;
            end
          end
          ONE: begin
            if (accept && drain) begin
              head_q <= in_entry;
`ifdef IF_ID_SKID_EN
            end else if (accept) begin
              state      <= TWO;
              skid_q     <= in_entry;
              in_ready_q <= 1'b0;
`endif
            end else if (drain) begin
              // Payload is left as-is when draining to empty.
              state     <= EMPTY;
              out_valid <= 1'b0;
            end
          end
`ifdef IF_ID_SKID_EN
          TWO: begin
            if (drain) begin
              state      <= ONE;
              head_q     <= skid_q;
              in_ready_q <= 1'b1;
            end
          end
`endif
          default: begin
            state     <= EMPTY;
            out_valid <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_if_id_pipe.sv
// Self-checking bench for if_id_pipe: queue-based reference model, directed scenarios, random stimulus.
module tb_if_id_pipe;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] inst;
    logic        intr;
  } ent_t;

  localparam logic [31:0] NOP    = 32'h0000_0000;
  localparam ent_t        BUBBLE = '{pc: 32'h0, pc4: 32'h0, inst: NOP, intr: 1'b0};

  logic        clk, rst, flush, in_valid, in_intr, out_ready;
  logic [31:0] in_pc, in_inst;
  logic        in_ready, out_valid, out_intr;
  logic [31:0] out_pc, out_pc4, out_inst;
  logic [15:0] stall_cnt;
  logic        in_ready_b, out_valid_b, out_intr_b;
  logic [31:0] out_pc_b, out_pc4_b, out_inst_b;
  logic [3:0]  stall_cnt_b;

  int checks = 0;
  int errors = 0;

  if_id_pipe dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_inst(in_inst), .in_intr(in_intr),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_pc4(out_pc4), .out_inst(out_inst), .out_intr(out_intr),
    .stall_cnt(stall_cnt)
  );

  if_id_pipe #(.CNT_W(4)) dut_c4 (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready_b),
    .in_pc(in_pc), .in_inst(in_inst), .in_intr(in_intr),
    .out_valid(out_valid_b), .out_ready(out_ready),
    .out_pc(out_pc_b), .out_pc4(out_pc4_b), .out_inst(out_inst_b), .out_intr(out_intr_b),
    .stall_cnt(stall_cnt_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: an in-order queue of captured entries plus the payload shown when empty.
  ent_t        q[$];
  ent_t        shown = BUBBLE;
  int unsigned stalls = 0;
  bit          started = 1'b0;

  always @(posedge clk) begin : model
    ent_t e;
    bit   rdy, acc, drn;
    if (rst) begin
      q.delete();
      shown   = BUBBLE;
      stalls  = 0;
      started = 1'b1;
    end else if (started) begin
`ifdef IF_ID_SKID_EN
      rdy = q.size() < 2;
`else
      rdy = (q.size() == 0) || out_ready;
`endif
      acc = in_valid && rdy;
      drn = (q.size() > 0) && out_ready;
      if (q.size() > 0 && !out_ready) stalls++;
      if (flush) begin
        q.delete();
        shown = BUBBLE;
      end else begin
        if (drn) void'(q.pop_front());
        if (acc) begin
          e.pc   = in_pc;
          e.pc4  = in_pc + 32'd4;
          e.inst = in_inst;
          e.intr = in_intr;
          q.push_back(e);
        end
        if (q.size() > 0) shown = q[0];
      end
    end
  end

  always @(negedge clk) begin : compare
    if (started) begin
      check("out_valid", 64'(out_valid), 64'(q.size() > 0));
      check("out_pc",    64'(out_pc),    64'(shown.pc));
      check("out_pc4",   64'(out_pc4),   64'(shown.pc4));
      check("out_inst",  64'(out_inst),  64'(shown.inst));
      check("out_intr",  64'(out_intr),  64'(shown.intr));
      check("stall_cnt", 64'(stall_cnt), 64'(stalls > 65535 ? 65535 : stalls));
      check("c4_valid",  64'(out_valid_b), 64'(q.size() > 0));
      check("c4_pc",     64'(out_pc_b),    64'(shown.pc));
      check("c4_stall",  64'(stall_cnt_b), 64'(stalls > 15 ? 15 : stalls));
`ifdef IF_ID_SKID_EN
      if (!rst) check("in_ready", 64'(in_ready), 64'(q.size() < 2));
`else
      check("in_ready", 64'(in_ready), 64'(rst || q.size() == 0 || out_ready));
`endif
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_pc = 32'h0; in_inst = 32'h0; in_intr = 1'b0;
    cyc(); cyc();
    check("rst_valid", 64'(out_valid), 64'(0));
    check("rst_pc",    64'(out_pc),    64'(0));
    check("rst_pc4",   64'(out_pc4),   64'(0));
    check("rst_inst",  64'(out_inst),  64'(NOP));
    check("rst_intr",  64'(out_intr),  64'(0));
    check("rst_stall", 64'(stall_cnt), 64'(0));
    rst = 1'b0;
    #1;
    check("rst_in_ready", 64'(in_ready), 64'(1));

    // Streaming with no bubbles.
    in_valid = 1'b1; out_ready = 1'b1; in_inst = 32'h0000_0013;
    in_pc = 32'h100; cyc();
    check("s0_valid", 64'(out_valid), 64'(1));
    check("s0_pc",    64'(out_pc),  64'h100);
    check("s0_pc4",   64'(out_pc4), 64'h104);
    in_pc = 32'h104; cyc();
    check("s1_pc",    64'(out_pc),  64'h104);
    check("s1_pc4",   64'(out_pc4), 64'h108);
    in_pc = 32'h108; cyc();
    check("s2_pc",    64'(out_pc),  64'h108);
    check("s2_pc4",   64'(out_pc4), 64'h10C);
    check("s2_stall", 64'(stall_cnt), 64'(0));

    // One cycle of backpressure.
`ifdef IF_ID_SKID_EN
    in_pc = 32'h10C; out_ready = 1'b0; #1;
    check("bp_ready_pre", 64'(in_ready), 64'(1));
    cyc();
    check("bp_two_ready", 64'(in_ready), 64'(0));
    check("bp_two_pc",    64'(out_pc),   64'h108);
    check("bp_stall",     64'(stall_cnt), 64'(1));
    out_ready = 1'b1; in_pc = 32'h110; cyc();
    check("bp_pop_pc",    64'(out_pc),   64'h10C);
    check("bp_pop_ready", 64'(in_ready), 64'(1));
    cyc();
    check("bp_next_pc",   64'(out_pc),   64'h110);
`else
    in_pc = 32'h10C; out_ready = 1'b0; #1;
    check("bp_ready_track0", 64'(in_ready), 64'(0));
    cyc();
    check("bp_hold_pc", 64'(out_pc), 64'h108);
    check("bp_stall",   64'(stall_cnt), 64'(1));
    out_ready = 1'b1; #1;
    check("bp_ready_track1", 64'(in_ready), 64'(1));
    cyc();
    check("bp_pop_pc", 64'(out_pc), 64'h10C);
    in_pc = 32'h110; cyc();
    check("bp_next_pc", 64'(out_pc), 64'h110);
`endif
    check("bp_stall_final", 64'(stall_cnt), 64'(1));

    // Flush with a same-cycle fetch of 0x208.
    in_pc = 32'h200; out_ready = 1'b1; cyc();
    check("fl_head", 64'(out_pc), 64'h200);
    in_pc = 32'h204; out_ready = 1'b0; cyc();
    check("fl_hold_pc", 64'(out_pc), 64'h200);
`ifdef IF_ID_SKID_EN
    check("fl_two_ready", 64'(in_ready), 64'(0));
`endif
    flush = 1'b1; in_pc = 32'h208; cyc();
    check("fl_valid", 64'(out_valid), 64'(0));
    check("fl_pc",    64'(out_pc),    64'(0));
    check("fl_pc4",   64'(out_pc4),   64'(0));
    check("fl_inst",  64'(out_inst),  64'(NOP));
    check("fl_stall", 64'(stall_cnt), 64'(3));
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; cyc();
    check("fl_after_valid", 64'(out_valid), 64'(0));

    // PC+4 wrap and interrupt tag, then drain leaves payload in place.
    in_valid = 1'b1; in_pc = 32'hFFFF_FFFC; in_intr = 1'b1; in_inst = 32'hDEAD_BEEF; cyc();
    check("wrap_pc",   64'(out_pc),   64'hFFFF_FFFC);
    check("wrap_pc4",  64'(out_pc4),  64'h0);
    check("wrap_intr", 64'(out_intr), 64'(1));
    check("wrap_inst", 64'(out_inst), 64'hDEAD_BEEF);
    in_valid = 1'b0; in_intr = 1'b0; cyc();
    check("drain_valid", 64'(out_valid), 64'(0));
    check("drain_pc",    64'(out_pc),    64'hFFFF_FFFC);

    // Counter saturation on the 4-bit instance; flush keeps it, reset clears it.
    in_valid = 1'b1; in_pc = 32'h300; in_inst = 32'h0010_0093; cyc();
    in_valid = 1'b0; out_ready = 1'b0;
    repeat (20) cyc();
    check("sat_c4",  64'(stall_cnt_b), 64'(15));
    check("sat_c16", 64'(stall_cnt),   64'(23));
    flush = 1'b1; cyc(); flush = 1'b0;
    check("sat_flush_c4",  64'(stall_cnt_b), 64'(15));
    check("sat_flush_c16", 64'(stall_cnt),   64'(24));
    rst = 1'b1; cyc(); rst = 1'b0;
    check("sat_rst_c4",  64'(stall_cnt_b), 64'(0));
    check("sat_rst_c16", 64'(stall_cnt),   64'(0));

    // Reset while holding entries.
    in_valid = 1'b1; out_ready = 1'b0; in_pc = 32'h400; cyc();
    in_pc = 32'h404; cyc();
    check("mr_full", 64'(out_valid), 64'(1));
    rst = 1'b1; in_pc = 32'h408; cyc();
    rst = 1'b0; in_valid = 1'b0;
    check("mr_valid", 64'(out_valid), 64'(0));
    check("mr_pc",    64'(out_pc),    64'(0));
    check("mr_pc4",   64'(out_pc4),   64'(0));
    check("mr_inst",  64'(out_inst),  64'(NOP));
    check("mr_intr",  64'(out_intr),  64'(0));
    check("mr_stall", 64'(stall_cnt), 64'(0));

    // Random traffic against the model.
    for (int i = 0; i < 1000; i++) begin
      in_valid  = $urandom_range(0, 9) < 7;
      out_ready = ((i % 100) < 22) ? 1'b0 : ($urandom_range(0, 9) < 7);
      flush     = $urandom_range(0, 24) == 0;
      rst       = $urandom_range(0, 79) == 0;
      in_intr   = $urandom_range(0, 7) == 0;
      in_inst   = $urandom;
      in_pc     = ($urandom_range(0, 9) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hC))
                                              : ($urandom & 32'hFFFF_FFFC);
      cyc();
    end
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    cyc(); cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
